// File: rtl/alu_cmd_sequencer_if.sv
// Command and response streams of alu_cmd_sequencer.
// master = command producer / response consumer, slave = the sequencer.
`timescale 1ns/1ps
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               cmd_a;
    logic [7:0]               cmd_b;
    logic [2:0]               cmd_op;
    logic [$clog2(DEPTH):0]   cmd_count;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [15:0]              rsp_result;
    logic                     rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, cmd_count, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, cmd_count, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// FIFO-buffered command issuer for the single-cycle ALU; one command in flight,
// responses in issue order. Define SEQ_TIMEOUT_EN to add the WAIT-state timeout.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    alu_cmd_sequencer_if.slave        bus,
    output logic [7:0]                A,
    output logic [7:0]                B,
    output logic [2:0]                op,
    output logic                      start,
    input  logic                      done_aax,
    input  logic [15:0]               result_aax
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
            $error("alu_cmd_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [18:0]   fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic [2:0]    head_op;
    logic          head_legal;

    logic          load_cmd;
    logic          load_err;
    logic          capture;
    logic          timed_out;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty         = (wr_ptr == rd_ptr);
    assign push          = bus.cmd_valid && !full;
    assign bus.cmd_ready = !full;
    assign bus.cmd_count = wr_ptr - rd_ptr;

    assign {head_op, head_b, head_a} = fifo_mem[rd_ptr[AW-1:0]];
    assign head_legal = head_op inside {3'd1, 3'd2, 3'd3};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Held at zero outside WAIT so every WAIT entry starts a fresh count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    assign timed_out = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_cmd   = 1'b0;
        load_err   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_cmd   = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        load_err   = 1'b1;
                        next_state = RESP;
                    end
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (done_aax) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else if (timed_out) begin
                    load_err   = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operands hold between issues; the response holds until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            A              <= '0;
            B              <= '0;
            op             <= '0;
            start          <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            start         <= load_cmd;
            bus.rsp_valid <= (next_state == RESP);
            if (load_cmd) begin
                A  <= head_a;
                B  <= head_b;
                op <= head_op;
            end
            if (load_err) begin
                bus.rsp_result <= '0;
                bus.rsp_err    <= 1'b1;
            end else if (capture) begin
                bus.rsp_result <= result_aax;
                bus.rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed steps plus random traffic
// scored against a queue-based reference model. Honours SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done_aax;
    logic [15:0] result_aax;

    alu_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .A          (A),
        .B          (B),
        .op         (op),
        .start      (start),
        .done_aax   (done_aax),
        .result_aax (result_aax)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit suppress_done = 1'b0;
    bit rand_ready = 1'b0;
    int start_cnt = 0;
    int rsp_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef struct {
        logic [15:0] result;
        logic        err;
    } rsp_t;

    cmd_t iss_q[$];
    rsp_t rsp_q[$];
    cmd_t mon_cmd;
    rsp_t mon_rsp;

    function automatic logic [15:0] refResult(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        case (o)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic refErr(input logic [2:0] o);
        return !(o >= 3'd1 && o <= 3'd3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle ALU: done one cycle after start, optionally muted.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_aax   <= 1'b0;
            result_aax <= 16'h0000;
        end else begin
            done_aax   <= start && !suppress_done;
            result_aax <= refResult(A, B, op);
        end
    end

    // Scoreboard: predicts issues and responses from accepted commands.
    always @(negedge clk) begin
        if (!reset_n) begin
            iss_q.delete();
            rsp_q.delete();
        end else if (mon_en) begin
            if (start) begin
                start_cnt++;
                checkOutput("issue_expected", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    mon_cmd = iss_q.pop_front();
                    checkOutput("issue_A", 32'(A), 32'(mon_cmd.a));
                    checkOutput("issue_B", 32'(B), 32'(mon_cmd.b));
                    checkOutput("issue_op", 32'(op), 32'(mon_cmd.op));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                checkOutput("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_q.size() > 0) begin
                    mon_rsp = rsp_q.pop_front();
                    checkOutput("rsp_result", 32'(bus.rsp_result), 32'(mon_rsp.result));
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(mon_rsp.err));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                rsp_q.push_back('{refResult(bus.cmd_a, bus.cmd_b, bus.cmd_op), refErr(bus.cmd_op)});
                if (!refErr(bus.cmd_op)) begin
                    iss_q.push_back('{bus.cmd_a, bus.cmd_b, bus.cmd_op});
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        bit acc;
        acc = 1'b0;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = o;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
            acc = bus.cmd_ready;
            tick();
            if (acc) break;
        end
        bus.cmd_valid = 1'b0;
        checkOutput("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic waitDrain(input int max_cycles);
        rand_ready    = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (rsp_q.size() == 0 && iss_q.size() == 0 && bus.cmd_count == 0 && !bus.rsp_valid) break;
            tick();
        end
        checkOutput("drain_pending", 32'(rsp_q.size()), 32'd0);
    endtask

    task automatic waitRespValid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) break;
            tick();
        end
        checkOutput(tag, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_A"}, 32'(A), 32'd0);
        checkOutput({tag, "_B"}, 32'(B), 32'd0);
        checkOutput({tag, "_op"}, 32'(op), 32'd0);
        checkOutput({tag, "_start"}, 32'(start), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        checkOutput({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_start;
        int base_rsp;
        int n;
        bit seen;

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b1;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        $display("[TB] step 1: single ADD latency");
        bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01; bus.cmd_op = 3'd1; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checkOutput("t1_count_c1", 32'(bus.cmd_count), 32'd1);
        checkOutput("t1_start_c1", 32'(start), 32'd0);
        tick();
        checkOutput("t1_start_c2", 32'(start), 32'd1);
        checkOutput("t1_A_c2", 32'(A), 32'hFF);
        checkOutput("t1_B_c2", 32'(B), 32'h01);
        checkOutput("t1_op_c2", 32'(op), 32'd1);
        tick();
        checkOutput("t1_start_c3", 32'(start), 32'd0);
        checkOutput("t1_valid_c3", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("t1_valid_c4", 32'(bus.rsp_valid), 32'd1);
        checkOutput("t1_result_c4", 32'(bus.rsp_result), 32'h0100);
        checkOutput("t1_err_c4", 32'(bus.rsp_err), 32'd0);
        tick();
        checkOutput("t1_valid_c5", 32'(bus.rsp_valid), 32'd0);

        $display("[TB] step 2: back-pressure fills the FIFO");
        bus.rsp_ready = 1'b0;
        base_rsp = rsp_cnt;
        applyStimulus(8'h11, 8'h22, 3'd1);
        waitRespValid("t2_held_resp");
        applyStimulus(8'hF0, 8'h3C, 3'd2);
        applyStimulus(8'hAA, 8'hFF, 3'd3);
        applyStimulus(8'h80, 8'h80, 3'd1);
        applyStimulus(8'h01, 8'h01, 3'd1);
        checkOutput("t2_count_full", 32'(bus.cmd_count), 32'd4);
        checkOutput("t2_ready_full", 32'(bus.cmd_ready), 32'd0);
        repeat (3) tick();
        checkOutput("t2_count_held", 32'(bus.cmd_count), 32'd4);
        checkOutput("t2_result_held", 32'(bus.rsp_result), 32'h0033);
        waitDrain(100);
        checkOutput("t2_rsp_total", 32'(rsp_cnt - base_rsp), 32'd5);

        $display("[TB] step 3: illegal opcodes");
        base_start = start_cnt;
        base_rsp   = rsp_cnt;
        applyStimulus(8'h12, 8'h34, 3'd0);
        applyStimulus(8'h56, 8'h78, 3'd7);
        waitDrain(50);
        checkOutput("t3_no_start", 32'(start_cnt - base_start), 32'd0);
        checkOutput("t3_rsp_total", 32'(rsp_cnt - base_rsp), 32'd2);

        $display("[TB] step 4: full FIFO stalls a held command, pointers wrap");
        bus.rsp_ready = 1'b0;
        base_rsp = rsp_cnt;
        applyStimulus(8'h05, 8'h06, 3'd3);
        waitRespValid("t4_held_resp");
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(1, 3)));
        bus.cmd_a = 8'h9C; bus.cmd_b = 8'h0F; bus.cmd_op = 3'd2; bus.cmd_valid = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            seen |= bus.cmd_ready;
            tick();
        end
        checkOutput("t4_ready_while_full", 32'(seen), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        checkOutput("t4_ready_before_pop", 32'(bus.cmd_ready), 32'd0);
        tick();
        checkOutput("t4_ready_after_pop", 32'(bus.cmd_ready), 32'd1);
        checkOutput("t4_count_after_pop", 32'(bus.cmd_count), 32'd3);
        tick();
        bus.cmd_valid = 1'b0;
        checkOutput("t4_count_after_push", 32'(bus.cmd_count), 32'd4);
        rand_ready = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(1, 3)));
        waitDrain(200);
        checkOutput("t4_rsp_total", 32'(rsp_cnt - base_rsp), 32'd11);

        $display("[TB] step 5: reset while waiting on the ALU");
        bus.rsp_ready = 1'b1;
        suppress_done = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(1, 3)));
        checkOutput("t5_count_before", 32'(bus.cmd_count), 32'd3);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("t5_reset");
        tick();
        reset_n = 1'b1;
        suppress_done = 1'b0;
        base_start = start_cnt;
        base_rsp   = rsp_cnt;
        seen = 1'b0;
        repeat (20) begin
            seen |= bus.rsp_valid | start;
            tick();
        end
        checkOutput("t5_quiet_after_reset", 32'(seen), 32'd0);
        checkOutput("t5_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
        checkOutput("t5_count_after", 32'(bus.cmd_count), 32'd0);

        $display("[TB] step 6: ALU never completes");
        mon_en = 1'b0;
        suppress_done = 1'b1;
        bus.rsp_ready = 1'b1;
        applyStimulus(8'h21, 8'h43, 3'd1);
        for (int i = 0; i < 10; i++) begin
            if (start) break;
            tick();
        end
        checkOutput("t6_start_seen", 32'(start), 32'd1);
        n = 0;
        while (n < 40 && !bus.rsp_valid) begin
            tick();
            n++;
        end
`ifdef SEQ_TIMEOUT_EN
        checkOutput("t6_timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
        checkOutput("t6_timeout_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("t6_timeout_result", 32'(bus.rsp_result), 32'd0);
        tick();
        checkOutput("t6_valid_cleared", 32'(bus.rsp_valid), 32'd0);
`else
        checkOutput("t6_no_response", 32'(bus.rsp_valid), 32'd0);
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        suppress_done = 1'b0;
        mon_en = 1'b1;
        tick();

        $display("[TB] step 7: random traffic");
        base_rsp = rsp_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        waitDrain(400);
        checkOutput("t7_rsp_total", 32'(rsp_cnt - base_rsp), 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
